beam_forming_sad_search: RTL



---
 rtl/bf_pkg.sv | 32 +++
 rtl/bf_sad_accum.sv | 37 +++
 rtl/beam_forming_sad_search.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bf_pkg.sv
// Shared types and width helpers for the beam-forming SAD lag search.
package bf_pkg;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        SEARCH  = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } bf_state_t;

    function automatic int nlag(input int max_lag);
        return 2 * max_lag + 1;
    endfunction

    function automatic int buf_len(input int win, input int max_lag);
        return win + 2 * max_lag;
    endfunction

    function automatic int acc_w(input int data_width, input int win);
        return data_width + 1 + $clog2(win);
    endfunction

    function automatic int lag_w(input int max_lag);
        return $clog2(max_lag + 1) + 1;
    endfunction

    // Lag index 0..n_lag-1 spread evenly over the LED bar, floor division.
    function automatic int led_index(input int lag_idx, input int num_leds, input int n_lag);
        return (lag_idx * num_leds) / n_lag;
    endfunction

endpackage

// File: rtl/bf_sad_accum.sv
// Absolute-difference accumulator: acc += |a - b| per enabled cycle, clear wins.
module bf_sad_accum #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_W      = 22
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_W-1:0]      acc
);

    logic signed [DATA_WIDTH:0] diff;
    logic        [DATA_WIDTH:0] abs_diff;
    logic        [ACC_W-1:0]    acc_reg;

    // One extra bit keeps the signed difference exact; its magnitude fits unsigned.
    always_comb begin
        diff     = $signed({a[DATA_WIDTH-1], a}) - $signed({b[DATA_WIDTH-1], b});
        abs_diff = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
        end else if (enable) begin
            acc_reg <= acc_reg + ACC_W'(abs_diff);
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/beam_forming_sad_search.sv
// Two-channel direction finder: captures a frame, searches the minimum-SAD lag.
// Define BF_SCORE_OUT_EN to expose the winning SAD on min_sad.
module beam_forming_sad_search
    import bf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int WIN        = 32,
    parameter int MAX_LAG    = 15,
    parameter int NUM_LEDS   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          left_in,
    input  logic [DATA_WIDTH-1:0]          right_in,
    output logic                           result_valid,
    output logic [lag_w(MAX_LAG)-1:0]      best_lag,
    output logic [NUM_LEDS-1:0]            led_pattern,
    output logic                           busy
`ifdef BF_SCORE_OUT_EN
    ,
    output logic [acc_w(DATA_WIDTH, WIN)-1:0] min_sad
`endif
);

    localparam int NLAG    = nlag(MAX_LAG);
    localparam int BUF_LEN = buf_len(WIN, MAX_LAG);
    localparam int ACC_W   = acc_w(DATA_WIDTH, WIN);
    localparam int LAG_W   = lag_w(MAX_LAG);
    localparam int ADDR_W  = $clog2(BUF_LEN);
    localparam int J_W     = $clog2(WIN);
    localparam int LIDX_W  = $clog2(NLAG);

    bf_state_t state_reg, state_next;

    logic [ADDR_W-1:0]     cap_cnt_reg;
    logic [J_W-1:0]        j_reg;
    logic [LIDX_W-1:0]     lag_reg;
    logic                  prime_reg;
    logic [ACC_W-1:0]      best_sad_reg;
    logic [LIDX_W-1:0]     best_idx_reg;
    logic [LAG_W-1:0]      best_lag_reg;
    logic [NUM_LEDS-1:0]   led_reg;

    logic [DATA_WIDTH-1:0] left_mem  [BUF_LEN];
    logic [DATA_WIDTH-1:0] right_mem [BUF_LEN];
    logic [DATA_WIDTH-1:0] l_q, r_q;

    logic                  accept, cap_last, j_last, lag_last;
    logic                  rd_en, acc_en, acc_clr;
    logic [J_W-1:0]        rd_j;
    logic [LIDX_W-1:0]     rd_lag;
    logic [ADDR_W-1:0]     rd_addr_l, rd_addr_r;
    logic [ACC_W-1:0]      acc, win_sad;
    logic [LIDX_W-1:0]     win_idx;
    logic [NUM_LEDS-1:0]   led_next;
    int                    led_idx;

    assign cap_last = (cap_cnt_reg == ADDR_W'(BUF_LEN - 1));
    assign j_last   = (j_reg == J_W'(WIN - 1));
    assign lag_last = (lag_reg == LIDX_W'(NLAG - 1));

    // Reads are issued one cycle ahead of the term they feed, so the read
    // registers always hold the pair being accumulated in the current cycle.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        rd_en      = 1'b0;
        rd_j       = '0;
        rd_lag     = lag_reg;
        acc_en     = 1'b0;
        acc_clr    = 1'b0;
        case (state_reg)
            CAPTURE: begin
                accept = in_valid;
                if (in_valid && cap_last) begin
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (prime_reg) begin
                    rd_en = 1'b1;
                end else begin
                    acc_en = 1'b1;
                    if (j_last) begin
                        state_next = COMPARE;
                    end else begin
                        rd_en = 1'b1;
                        rd_j  = j_reg + J_W'(1);
                    end
                end
            end
            COMPARE: begin
                acc_clr = 1'b1;
                if (lag_last) begin
                    state_next = DONE;
                end else begin
                    state_next = SEARCH;
                    rd_en      = 1'b1;
                    rd_lag     = lag_reg + LIDX_W'(1);
                end
            end
            DONE: begin
                state_next = CAPTURE;
            end
            default: begin
                state_next = CAPTURE;
            end
        endcase
    end

    // L[MAX_LAG+j] against R[MAX_LAG+j+k] with k = lag_idx - MAX_LAG.
    assign rd_addr_l = ADDR_W'(MAX_LAG) + ADDR_W'(rd_j);
    assign rd_addr_r = ADDR_W'(rd_j) + ADDR_W'(rd_lag);

    always_ff @(posedge clk) begin
        if (accept) begin
            left_mem[cap_cnt_reg]  <= left_in;
            right_mem[cap_cnt_reg] <= right_in;
        end
        if (rd_en) begin
            l_q <= left_mem[rd_addr_l];
            r_q <= right_mem[rd_addr_r];
        end
    end

    bf_sad_accum #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_W     (ACC_W)
    ) u_accum (
        .clk   (clk),
        .reset (reset),
        .clear (acc_clr),
        .enable(acc_en),
        .a     (l_q),
        .b     (r_q),
        .acc   (acc)
    );

    // Strict less-than keeps the earliest (most negative) lag on ties.
    always_comb begin
        win_sad = best_sad_reg;
        win_idx = best_idx_reg;
        if (acc < best_sad_reg) begin
            win_sad = acc;
            win_idx = lag_reg;
        end
        led_idx = led_index(int'(win_idx), NUM_LEDS, NLAG);
    end

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            assign led_next[gi] = (led_idx == gi);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= CAPTURE;
            cap_cnt_reg  <= '0;
            j_reg        <= '0;
            lag_reg      <= '0;
            prime_reg    <= 1'b0;
            best_sad_reg <= '1;
            best_idx_reg <= '0;
            best_lag_reg <= '0;
            led_reg      <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                CAPTURE: begin
                    if (accept) begin
                        if (cap_last) begin
                            cap_cnt_reg  <= '0;
                            prime_reg    <= 1'b1;
                            j_reg        <= '0;
                            lag_reg      <= '0;
                            best_sad_reg <= '1;
                        end else begin
                            cap_cnt_reg <= cap_cnt_reg + ADDR_W'(1);
                        end
                    end
                end
                SEARCH: begin
                    if (prime_reg) begin
                        prime_reg <= 1'b0;
                    end else if (j_last) begin
                        j_reg <= '0;
                    end else begin
                        j_reg <= j_reg + J_W'(1);
                    end
                end
                COMPARE: begin
                    best_sad_reg <= win_sad;
                    best_idx_reg <= win_idx;
                    if (lag_last) begin
                        best_lag_reg <= LAG_W'(win_idx) - LAG_W'(MAX_LAG);
                        led_reg      <= led_next;
                    end else begin
                        lag_reg <= lag_reg + LIDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BF_SCORE_OUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_sad <= '0;
        end else if (state_reg == COMPARE && lag_last) begin
            min_sad <= win_sad;
        end
    end
`else
    // Winning score remains internal in best_sad_reg.
`endif

    assign in_ready     = (state_reg == CAPTURE);
    assign busy         = (state_reg != CAPTURE);
    assign result_valid = (state_reg == DONE);
    assign best_lag     = best_lag_reg;
    assign led_pattern  = led_reg;

endmodule
